serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder sequencer: adds two WIDTH-bit operands plus carry-in using one
//  shared 1-bit full-adder cell (fa), one bit per clock, LSB first.
//  Operands arrive on a valid/ready input port; the result leaves on a valid/ready
//  output port.
//  Serves as the area-minimal arithmetic unit beside the fa cell; trades latency for a
//  single adder instance.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      op_a/op_b/cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  cin        in   1      carry-in
//  flush      in   1      synchronous abort of the current operation
//  busy       out  1      high in RUN
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  (op_a + op_b + cin) mod 2^WIDTH
//  cout       out  1      bit WIDTH of op_a + op_b + cin
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; a_sh, b_sh, sum_sh, carry and cnt clear to 0.
//    Outputs during reset: in_ready=1, busy=0, out_valid=0, sum=0, cout=0.
//  - Outputs are decoded from state or registers only; no combinational input->output
//    path.
//  - FSM:
//    IDLE: in_ready=1. On in_valid&&in_ready: a_sh<=op_a, b_sh<=op_b, carry<=cin,
//          cnt<=0; go to RUN.
//    RUN:  each cycle, fa is driven with a=a_sh[0], b=b_sh[0], cin=carry.
//          sum_sh<={fa.sum, sum_sh[WIDTH-1:1]}; carry<=fa.cout; a_sh, b_sh shift right;
//          cnt++. When cnt==WIDTH-1 (last bit), go to DONE.
//    DONE: out_valid=1; sum=sum_sh and cout=carry held stable until out_ready.
//          On out_ready, go to IDLE.
//  - Latency: accept edge to first out_valid cycle = WIDTH+1 cycles. Throughput: one
//    operation per WIDTH+2 cycles minimum (IDLE costs one cycle; no accept in DONE).
//  - Operands are captured only on the accept edge. in_valid and operand changes while
//    not IDLE are ignored; nothing is queued.
//  - sum/cout hold their last value after out_valid drops, until the next DONE.
//    Only out_valid qualifies them.
//  - flush:
//    In RUN: go to IDLE next edge, carry and cnt cleared, no out_valid ever raised.
//    In DONE: go to IDLE; the result is dropped.
//    In IDLE: no effect; flush takes priority over in_valid, so nothing is accepted.
//    flush together with out_ready in DONE: the transfer counts as complete; the next
//    state is IDLE either way.
//  - Async reset in RUN or DONE: the operation is discarded immediately, with no
//    partial result and no out_valid.
//  - cnt width is $clog2(WIDTH); cnt never exceeds WIDTH-1.
// STRUCTURE
//  - Package serial_add_pkg holds:
//    ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2-bit state encoding);
//    function cnt_w(WIDTH) = $clog2(WIDTH).
//  - Exactly one sub-module instance: the existing fa cell (a, b, cin -> sum, cout),
//    instance name u_fa.
//  - Remaining logic (FSM, shift registers, carry flop, counter) stays in this module.
// TESTING (WIDTH=8 unless noted; scoreboard = integer a+b+cin)
//  1. Reset: hold rst_n=0 -> in_ready=1, busy=0, out_valid=0, sum=0, cout=0.
//     Drop rst_n mid-RUN -> same values immediately, no out_valid afterwards.
//  2. Basic add: A=8'h0F, B=8'h01, cin=0 -> out_valid 9 cycles after accept,
//     sum=8'h10, cout=0, busy high for exactly 8 cycles.
//  3. Carry chain: A=8'hFF, B=8'h01, cin=0 -> sum=8'h00, cout=1.
//     A=8'hFF, B=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable.
//     in_valid pulses in that window are not accepted (in_ready=0). The op issued after
//     out_ready is correct.
//  5. Flush: assert flush on RUN cycle 3 of A=8'hAA, B=8'h55 -> IDLE next cycle,
//     no out_valid. Then A=8'h01, B=8'h01, cin=0 -> sum=8'h02 (carry was cleared).
//  6. Exhaustive WIDTH=2: all 32 {a,b,cin} combos with random out_ready stalls ->
//     zero scoreboard mismatches.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Package for the bit-serial adder sequencer.
// Holds the 2-bit FSM state encoding and the counter-width helper shared by
// the top module and anything that needs to size its step counter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the bit counter: enough to count 0 .. width-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// fa: the shared 1-bit full-adder cell.
// Ports:
//   a, b, cin  in   1  addend bits and carry-in
//   sum        out  1  a ^ b ^ cin
//   cout       out  1  majority(a, b, cin)
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Adds op_a + op_b + cin one bit per clock, LSB first, through a single shared
// full-adder cell. Operands enter on a valid/ready port (accepted only in IDLE),
// the WIDTH-bit sum and carry-out leave on a valid/ready port (held in DONE).
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   op_a/op_b  in   WIDTH  operands
//   cin        in   1      carry-in
//   flush      in   1      synchronous abort, returns to IDLE
//   busy       out  1      serial addition in progress (RUN)
//   out_valid  out  1      sum/cout valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  (op_a + op_b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;

    // Output registers: sum/cout must survive past DONE while the shifters
    // are reused by the next operation, so they are captured separately.
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             out_valid_r;

    logic             fa_sum_s;
    logic             fa_cout_s;

    fa u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Sequencer FSM with datapath shifters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            sum_sh_r    <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // flush outranks in_valid: nothing is accepted while flushing.
                    if (!flush && in_valid) begin
                        a_sh_r     <= op_a;
                        b_sh_r     <= op_b;
                        carry_r    <= cin;
                        cnt_r      <= '0;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        carry_r    <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
                        carry_r  <= fa_cout_s;
                        a_sh_r   <= a_sh_r >> 1;
                        b_sh_r   <= b_sh_r >> 1;
                        if (cnt_r == CNT_LAST) begin
                            // Last bit: publish the completed result directly from
                            // the adder so it is visible on the first DONE cycle.
                            cnt_r       <= '0;
                            sum_r       <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
                            cout_r      <= fa_cout_s;
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // out_ready completes the transfer; flush drops it. Either way
                    // the block returns to IDLE and sum/cout keep their value.
                    if (flush || out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    carry_r     <= 1'b0;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=8 instance exercised with a
// vector table, random operands and hand-written corner sequences, and a
// WIDTH=2 instance swept over every operand/carry combination. Expected sums
// come from plain integer addition a + b + cin.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       cin = 1'b0;
    logic       flush = 1'b0;
    logic       busy;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;

    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [1:0] op_a2 = 2'b00;
    logic [1:0] op_b2 = 2'b00;
    logic       cin2 = 1'b0;
    logic       flush2 = 1'b0;
    logic       busy2;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    logic [1:0] sum2;
    logic       cout2;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .flush(flush), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .op_a(op_a2), .op_b(op_b2), .cin(cin2), .flush(flush2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 transaction with latency, busy-length and stall checks.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] exp_sum, input logic exp_cout,
                           input int stall, input string name);
        int n;
        int lat;
        int busy_cnt;
        logic [7:0] held_sum;
        logic       held_cout;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin = c;
        tick();
        in_valid = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({name, " latency"}, lat, 32'd9);
        check({name, " busy cycles"}, busy_cnt, 32'd8);
        check({name, " sum"}, {24'd0, sum}, {24'd0, exp_sum});
        check({name, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
        held_sum = sum;
        held_cout = cout;
        for (int i = 0; i < stall; i++) begin
            // Offer junk operands that must be ignored while the result is pending.
            in_valid = 1'b1;
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            tick();
            check({name, " stall valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " stall in_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, " stall sum"}, {24'd0, sum}, {24'd0, held_sum});
            check({name, " stall cout"}, {31'd0, cout}, {31'd0, held_cout});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " valid drop"}, {31'd0, out_valid}, 32'd0);
        check({name, " back idle"}, {31'd0, in_ready}, 32'd1);
        check({name, " sum hold"}, {24'd0, sum}, {24'd0, exp_sum});
    endtask

    // One WIDTH=2 transaction against the integer scoreboard.
    task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic c,
                           input int stall);
        int n;
        int exp;
        exp = int'(a) + int'(b) + int'(c);
        n = 0;
        while (!in_ready2 && n < 20) begin
            tick();
            n++;
        end
        in_valid2 = 1'b1;
        op_a2 = a;
        op_b2 = b;
        cin2 = c;
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < stall; i++) tick();
        check($sformatf("w2 %0d+%0d+%0d", a, b, c), {29'd0, cout2, sum2}, exp);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   vcnt;
        int   exp;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        // Reset values while rst_n is held low.
        tick();
        tick();
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst sum", {24'd0, sum}, 32'd0);
        check("rst cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors; the first one also has a 5-cycle backpressure window.
        for (int i = 0; i < 8; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_cout,
                    (i == 0) ? 5 : (i % 3), $sformatf("vec%0d", i));
        end

        // Flush on the third RUN cycle: back to IDLE, no result ever appears.
        in_valid = 1'b1;
        op_a = 8'hAA;
        op_b = 8'h55;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush run in_ready", {31'd0, in_ready}, 32'd1);
        check("flush run busy", {31'd0, busy}, 32'd0);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) vcnt++;
            tick();
        end
        check("flush run no valid", vcnt, 32'd0);
        run_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, "after flush");

        // Flush in DONE drops the result.
        in_valid = 1'b1;
        op_a = 8'h11;
        op_b = 8'h22;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("done reached", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush done valid", {31'd0, out_valid}, 32'd0);
        check("flush done in_ready", {31'd0, in_ready}, 32'd1);

        // Flush in IDLE wins over in_valid.
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush idle busy", {31'd0, busy}, 32'd0);
        check("flush idle in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized operands against a + b + cin.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp = int'(ra) + int'(rb) + int'(rc);
            run_op8(ra, rb, rc, exp[7:0], exp[8], $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Async reset mid-RUN: outputs return to reset values without waiting for an edge.
        in_valid = 1'b1;
        op_a = 8'hF0;
        op_b = 8'h0F;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", {31'd0, in_ready}, 32'd1);
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst sum", {24'd0, sum}, 32'd0);
        check("async rst cout", {31'd0, cout}, 32'd0);
        tick();
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) vcnt++;
            tick();
        end
        check("async rst no valid", vcnt, 32'd0);

        // Exhaustive WIDTH=2 sweep with random result stalls.
        for (int k = 0; k < 32; k++) begin
            logic [4:0] combo;
            combo = 5'(k);
            run_op2(combo[4:3], combo[2:1], combo[0], $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
